// File: rtl/lifo_reader.sv
// lifo_reader: burst pop engine between a lifo read port and a valid/ready consumer.
// Define LIFO_READER_LAST_EN to drive m_last on the final beat of each burst.
module lifo_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 12,
    localparam int unsigned LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LW-1:0]         cmd_len,
    output logic                  lifo_rd_en,
    input  logic [DATA_WIDTH-1:0] lifo_data_rd,
    input  logic                  lifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done,
    output logic                  short,
    output logic [LW-1:0]         pop_cnt
);

    typedef enum logic [1:0] {IDLE, POP, DRAIN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [LW-1:0]                   remaining_q, remaining_d;
    logic [LW-1:0]                   pop_cnt_q, pop_cnt_d;
    logic                            short_q, short_d;
    logic                            inflight_q;
    logic                            cmd_ready_q;
    logic                            done_q;
    logic                            rd_en;
    logic                            out_pop;
    logic [LW-1:0]                   len_sat;
    logic [1:0]                      occ_after;
    logic [1:0][DATA_WIDTH-1:0]      skid_q;
    logic                            wr_ptr_q, rd_ptr_q;
    logic [1:0]                      count_q;

    assign len_sat   = (cmd_len > LW'(DEPTH)) ? LW'(DEPTH) : cmd_len;
    assign m_valid   = (count_q != 2'd0);
    assign m_data    = skid_q[rd_ptr_q];
    assign out_pop   = m_valid && m_ready;
    // Words held after this cycle's beat leaves, counting the read already in flight
    assign occ_after = count_q - 2'(out_pop) + 2'(inflight_q);

    assign lifo_rd_en = rd_en;
    assign cmd_ready  = cmd_ready_q;
    assign done       = done_q;
    assign short      = short_q;
    assign pop_cnt    = pop_cnt_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pop_cnt_d   = pop_cnt_q;
        short_d     = short_q;
        rd_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    remaining_d = len_sat;
                    pop_cnt_d   = '0;
                    short_d     = 1'b0;
                    state_d     = (len_sat == '0) ? DONE : POP;
                end
            end
            POP: begin
                if (remaining_q == '0) begin
                    state_d = DRAIN;
                end else if (lifo_empty && !inflight_q) begin
                    state_d = DRAIN;
                    short_d = 1'b1;
                end else if (!lifo_empty && (occ_after < 2'd2)) begin
                    rd_en       = 1'b1;
                    remaining_d = remaining_q - LW'(1);
                    pop_cnt_d   = pop_cnt_q + LW'(1);
                end
            end
            DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            pop_cnt_q   <= '0;
            short_q     <= 1'b0;
            inflight_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pop_cnt_q   <= pop_cnt_d;
            short_q     <= short_d;
            inflight_q  <= rd_en;
            cmd_ready_q <= (state_d == IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    // Two-entry skid FIFO absorbing the LIFO read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (inflight_q) begin
                skid_q[wr_ptr_q] <= lifo_data_rd;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (out_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(inflight_q) - 2'(out_pop);
        end
    end

`ifdef LIFO_READER_LAST_EN
    // Head is final when nothing else is buffered, in flight, or still to be popped
    assign m_last = m_valid && (count_q == 2'd1) && !inflight_q &&
                    ((state_q == DRAIN) ||
                     ((state_q == POP) && ((remaining_q == '0) || lifo_empty)));
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_reader.sv
// Directed bench for lifo_reader with a small behavioural LIFO on its read port.
module tb_lifo_reader;

`ifdef LIFO_READER_LAST_EN
    localparam bit LAST_EXP = 1'b1;
`else
    localparam bit LAST_EXP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_len;
    logic       lifo_rd_en;
    logic [7:0] lifo_data_rd;
    logic       lifo_empty;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       done;
    logic       short;
    logic [3:0] pop_cnt;

    lifo_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .lifo_rd_en   (lifo_rd_en),
        .lifo_data_rd (lifo_data_rd),
        .lifo_empty   (lifo_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .done         (done),
        .short        (short),
        .pop_cnt      (pop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LIFO model
    logic [7:0] lmem [12];
    logic [3:0] sp = 4'd0;
    logic       push_en;
    logic [7:0] push_data;
    int         underflow = 0;

    assign lifo_empty = (sp == 4'd0);

    always @(posedge clk) begin
        if (lifo_rd_en && sp != 4'd0) begin
            lifo_data_rd <= lmem[sp - 4'd1];
            sp           <= sp - 4'd1;
        end else if (push_en && sp < 4'd12) begin
            lmem[sp] <= push_data;
            sp       <= sp + 4'd1;
        end
        if (lifo_rd_en && sp == 4'd0) underflow <= underflow + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] got_q [$];
    bit         got_last [$];
    int         done_k, first_rd_k, first_v_k, pops, max_held;
    logic       done_short;
    logic [3:0] done_cnt;
    int         stall_bad = 0;
    int         last_bad = 0;
    bit         aborted;

    task automatic push_words(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = 8'(base + i * step);
            @(posedge clk); #1;
        end
        push_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rd_en"},     32'(lifo_rd_en), 32'd0);
        check({tag, "_m_valid"},   32'(m_valid), 32'd0);
        check({tag, "_m_data"},    32'(m_data), 32'd0);
        check({tag, "_m_last"},    32'(m_last), 32'd0);
        check({tag, "_done"},      32'(done), 32'd0);
        check({tag, "_short"},     32'(short), 32'd0);
        check({tag, "_pop_cnt"},   32'(pop_cnt), 32'd0);
    endtask

    // Issue one command and watch the burst; mode 0 = m_ready held, 1 = 1,0,0,1 then random
    task automatic run_burst(input int len, input int mode, input int budget, input int abort_after);
        bit         pat [4];
        bit         prev_stall;
        logic [7:0] prev_data;
        int         held;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        got_q.delete();
        got_last.delete();
        done_k = -1; first_rd_k = -1; first_v_k = -1; pops = 0; max_held = 0;
        aborted = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
        cmd_valid = 1'b1;
        cmd_len   = 4'(len);
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (mode == 0)   m_ready = 1'b1;
            else if (k <= 16) m_ready = pat[(k - 1) % 4];
            else             m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_bad++;
            if (m_last && !m_valid) last_bad++;
            if (lifo_rd_en && first_rd_k < 0) first_rd_k = k;
            if (m_valid && first_v_k < 0) first_v_k = k;
            held = pops - got_q.size();
            if (held > max_held) max_held = held;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last.push_back(m_last);
            end
            if (lifo_rd_en) pops++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) begin
                done_k     = k;
                done_short = short;
                done_cnt   = pop_cnt;
                check("cmd_ready_at_done", 32'(cmd_ready), 32'd0);
                break;
            end
            if (abort_after > 0 && got_q.size() == abort_after) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("burst_finished", 32'(done_k >= 0 || aborted), 32'd1);
        if (!aborted) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("cmd_ready_after", 32'(cmd_ready), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_beats(input string tag, input int n, input int top, input int step);
        check({tag, "_beats"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check({tag, "_data"}, 32'(got_q[i]), 32'(top - i * step));
            check({tag, "_last"}, 32'(got_last[i]), 32'(LAST_EXP && (i == n - 1)));
        end
    endtask

    task automatic check_end(input string tag, input int shrt, input int cnt);
        check({tag, "_short"},   32'(done_short), 32'(shrt));
        check({tag, "_pop_cnt"}, 32'(done_cnt), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = 4'd0; m_ready = 1'b1;
        push_en = 1'b0; push_data = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 10,20,30 with 30 on top
        push_words(3, 10, 10);
        run_burst(3, 0, 50, 0);
        check_beats("basic", 3, 30, 10);
        check_end("basic", 0, 3);
        check("basic_first_rd", 32'(first_rd_k), 32'd1);
        check("basic_first_valid", 32'(first_v_k), 32'd3);
        check("basic_done_cycle", 32'(done_k), 32'd7);

        // Short burst: 5 available, 8 requested
        push_words(5, 'h41, 1);
        run_burst(8, 0, 50, 0);
        check_beats("short5", 5, 'h45, 1);
        check_end("short5", 1, 5);
        check("short5_pops", 32'(pops), 32'd5);

        // Empty LIFO
        run_burst(4, 0, 50, 0);
        check_beats("empty", 0, 0, 1);
        check_end("empty", 1, 0);
        check("empty_pops", 32'(pops), 32'd0);
        check("empty_done_cycle", 32'(done_k), 32'd3);

        // Zero-length command on full LIFO
        push_words(12, 'h80, 1);
        run_burst(0, 0, 50, 0);
        check_beats("zero", 0, 0, 1);
        check_end("zero", 0, 0);
        check("zero_pops", 32'(pops), 32'd0);
        check("zero_done_cycle", 32'(done_k), 32'd1);

        // Full drain under backpressure
        stall_bad = 0;
        run_burst(12, 1, 400, 0);
        check_beats("stall", 12, 'h8b, 1);
        check_end("stall", 0, 12);
        check("stall_held_le2", 32'(max_held <= 2), 32'd1);
        check("stall_stable", 32'(stall_bad), 32'd0);

        // Saturating length
        push_words(12, 'hc0, 1);
        run_burst(15, 0, 60, 0);
        check_beats("sat", 12, 'hcb, 1);
        check_end("sat", 0, 12);
        check("sat_done_cycle", 32'(done_k), 32'd16);

        // Reset mid-burst after 3 beats; 08..05 have left the LIFO, 04 is next
        push_words(8, 1, 1);
        run_burst(6, 0, 50, 3);
        check("abort_taken", 32'(aborted), 32'd1);
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_burst(2, 0, 50, 0);
        check_beats("after_rst", 2, 4, 1);
        check_end("after_rst", 0, 2);
        check("after_rst_done_cycle", 32'(done_k), 32'd6);

        check("no_underflow", 32'(underflow), 32'd0);
        check("last_only_valid", 32'(last_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
